// File: rtl/full_adder_pkg.sv
// Shared constants for the full adder cell: reset value, result width, serial-mode encodings.
package full_adder_pkg;

    localparam int unsigned RESULT_W    = 32;
    localparam logic        RESET_VAL   = 1'b0;
    localparam logic        SER_ON      = 1'b1;
    localparam logic        START_ON    = 1'b1;
    localparam logic        CARRY_CLEAR = 1'b0;

    // Zero-extend a {carry, sum} pair to the full result width
    function automatic logic [RESULT_W-1:0] zext_result(input logic co, input logic s);
        return RESULT_W'({co, s});
    endfunction

endpackage

// File: rtl/half_adder.sv
// One-bit half adder; two of these plus an OR form the full adder core.
module half_adder (
    input  logic A,
    input  logic B,
    output logic S,
    output logic C
);

    assign S = A ^ B;
    assign C = A & B;

endmodule

// File: rtl/full_adder_cell.sv
// One-bit full adder with registered sum/carry copies.
// FULL_ADDER_SERIAL_EN adds SER/START and feeds CO_Q back as carry-in for bit-serial adds.
module full_adder_cell
    import full_adder_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic A,
    input  logic B,
    input  logic CI,
`ifdef FULL_ADDER_SERIAL_EN
    input  logic SER,
    input  logic START,
`endif
    output logic S,
    output logic CO,
    output logic S_Q,
    output logic CO_Q
);

    logic ci_eff;
    logic s1;
    logic c1;
    logic c2;
    logic s_d;
    logic co_d;
    logic s_q;
    logic co_q;

    // Carry-in select; ternaries keep X on SER/START visible instead of masking it
    always_comb begin
        ci_eff = CI;
`ifdef FULL_ADDER_SERIAL_EN
        ci_eff = (SER == SER_ON) ? ((START == START_ON) ? CARRY_CLEAR : co_q) : CI;
`endif
    end

    half_adder u_ha_ab (
        .A (A),
        .B (B),
        .S (s1),
        .C (c1)
    );

    half_adder u_ha_ci (
        .A (s1),
        .B (ci_eff),
        .S (S),
        .C (c2)
    );

    assign CO = c1 | c2;

    always_comb begin
        s_d  = S;
        co_d = CO;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s_q  <= RESET_VAL;
            co_q <= RESET_VAL;
        end else begin
            s_q  <= s_d;
            co_q <= co_d;
        end
    end

    assign S_Q  = s_q;
    assign CO_Q = co_q;

endmodule

// File: tb/tb_full_adder_cell.sv
// Scoreboard bench for full_adder_cell: stimulus queues expectations, a monitor pops and compares.
module tb_full_adder_cell;
    import full_adder_pkg::*;

    logic CLK;
    logic RST;
    logic A;
    logic B;
    logic CI;
    logic SER;
    logic START;
    logic S;
    logic CO;
    logic S_Q;
    logic CO_Q;

    int checks;
    int failures;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        logic [31:0] mask;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;

    localparam logic [31:0] M_COMB = 32'hFFFF_FFF3;
    localparam logic [31:0] M_REG  = 32'h0000_000C;
    localparam logic [31:0] M_ALL  = 32'h0000_000F;

    full_adder_cell dut (
        .CLK   (CLK),
        .RST   (RST),
        .A     (A),
        .B     (B),
        .CI    (CI),
`ifdef FULL_ADDER_SERIAL_EN
        .SER   (SER),
        .START (START),
`endif
        .S     (S),
        .CO    (CO),
        .S_Q   (S_Q),
        .CO_Q  (CO_Q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected word layout: bit3=S_Q, bit2=CO_Q, bit1=CO, bit0=S
    task automatic expect_val(input string tag, input logic [31:0] exp, input logic [31:0] mask);
        exp_t e;
        e.tag  = tag;
        e.exp  = exp;
        e.mask = mask;
        exp_q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    // Monitor: compares the DUT against the oldest queued expectation at each sample point
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            act = 32'({S_Q, CO_Q, CO, S});
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow: sample with no expectation, act=%h", act);
            end else begin
                e = exp_q.pop_front();
                if ((act & e.mask) !== (e.exp & e.mask)) begin
                    failures++;
                    $display("FAIL %s: actual=%h required=%h (mask %h)", e.tag, act & e.mask,
                             e.exp & e.mask, e.mask);
                end
            end
        end
    end

    initial begin
        logic [31:0] sum_tbl [8];
        logic [2:0]  idx;
        logic [3:0]  ser_a;
        logic [3:0]  ser_b;
        logic [3:0]  ser_s;
        logic [3:0]  ser_c;

        checks   = 0;
        failures = 0;
        sum_tbl  = '{32'h0, 32'h1, 32'h1, 32'h2, 32'h1, 32'h2, 32'h2, 32'h3};
        SER      = 1'b0;
        START    = 1'b0;

        // Reset held with all inputs high: comb follows inputs, registers stay cleared
        RST = 1'b0;
        A = 1'b1; B = 1'b1; CI = 1'b1;
        #1;
        expect_val("reset_asserted", 32'h3, M_ALL);
        @(posedge CLK); #1;
        expect_val("reset_hold_over_edge", 32'h3, M_ALL);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        expect_val("reset_first_capture", 32'hF, M_ALL);

        // Exhaustive combinational truth table, index {CI,A,B}
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            {CI, A, B} = idx;
            #1;
            expect_val($sformatf("comb_idx%0d", i), sum_tbl[i], M_COMB);
        end

        // Register latency
        @(negedge CLK);
        A = 1'b1; B = 1'b0; CI = 1'b0;
        @(posedge CLK); #1;
        expect_val("latency_first", 32'h8, M_REG);
        A = 1'b1; B = 1'b1;
        #1;
        expect_val("latency_hold", 32'hA, M_ALL);
        @(posedge CLK); #1;
        expect_val("latency_update", 32'h4, M_REG);

        // Asynchronous reset between edges
        @(negedge CLK);
        A = 1'b1; B = 1'b1; CI = 1'b1;
        @(posedge CLK); #1;
        expect_val("async_pre", 32'hC, M_REG);
        #1;
        RST = 1'b0;
        #1;
        expect_val("async_clear", 32'h3, M_ALL);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        expect_val("async_recover", 32'hF, M_ALL);

`ifdef FULL_ADDER_SERIAL_EN
        // 0xB + 0x6 LSB first; CI held high to show it is ignored in serial mode
        ser_a = 4'hB;
        ser_b = 4'h6;
        ser_s = 4'b0001;
        ser_c = 4'b1110;
        @(negedge CLK);
        SER = 1'b1;
        CI  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            START = (i == 0);
            A = ser_a[i];
            B = ser_b[i];
            @(posedge CLK); #1;
            expect_val($sformatf("serial_bit%0d", i), 32'({ser_s[i], ser_c[i], 2'b00}), M_REG);
        end

        // START after a carry-out word must discard the carry
        @(negedge CLK);
        START = 1'b1;
        A = 1'b0; B = 1'b0;
        #1;
        expect_val("serial_start_comb", 32'h4, M_ALL);
        @(posedge CLK); #1;
        expect_val("serial_start_reg", 32'h0, M_REG);
        @(negedge CLK);
        SER = 1'b0;
        START = 1'b0;
`else
        ser_a = 4'h0;
        ser_b = 4'h0;
        ser_s = 4'h0;
        ser_c = 4'h0;
`endif

        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: actual=%0d pending required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
